// File: rtl/ord_arbiter.sv
// Two-requester round-robin front end for a single job engine: grant, fetch/emit relay, watchdog abort.
// Fetch/emit/ack responses are one cycle after the request; an emit holds out_dat until the granted eack arrives.
module ord_arbiter #(
  parameter int W      = 8,
  parameter int WD_MAX = 255
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic [1:0]   req,
  input  logic [W-1:0] len0,
  input  logic [W-1:0] len1,
  input  logic [W-1:0] dat0,
  input  logic [W-1:0] dat1,
  input  logic [1:0]   fvalid,
  output logic [1:0]   fetch,
  output logic [1:0]   emit,
  input  logic [1:0]   eack,
  output logic [W-1:0] out_dat,
  output logic [1:0]   gnt,
  output logic [1:0]   done,
  output logic [1:0]   err,
  output logic         eng_start,
  output logic [W-1:0] eng_A,
  output logic [W-1:0] eng_B,
  input  logic         eng_ack,
  input  logic         eng_start2,
  output logic         eng_ack2,
  input  logic         eng_start3,
  input  logic [W-1:0] eng_R,
  output logic         eng_ack3
);

  localparam int WDW = (WD_MAX < 2) ? 1 : $clog2(WD_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_DONE, S_ABORT} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_g;
  logic           r_last;
  logic [1:0]     r_gnt;
  logic [1:0]     r_fetch;
  logic [1:0]     r_emit;
  logic           r_fout;
  logic           r_pe;
  logic           r_ack2;
  logic           r_ack3;
  logic [W-1:0]   r_eng_a;
  logic [W-1:0]   r_eng_b;
  logic [W-1:0]   r_out;
  logic [WDW-1:0] r_wd;

  logic           w_gi;
  logic [1:0]     w_onehot;
  logic           w_fv;
  logic           w_ea;
  logic           w_act;
  logic           w_wd_hit;
  logic           w_fbusy;

  // On a tie the requester that was not served last wins.
  assign w_gi     = (req == 2'b11) ? ~r_last : req[1];
  assign w_onehot = r_g ? 2'b10 : 2'b01;
  assign w_fv     = fvalid[r_g];
  assign w_ea     = eack[r_g];
  assign w_act    = eng_start2 | eng_start3 | w_fv | w_ea;
  assign w_wd_hit = !w_act && (r_wd == WDW'(WD_MAX - 1));
  // An emit may not start while a fetch is being requested or awaits its data.
  assign w_fbusy  = eng_start2 | r_fout;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (|req) w_state_nxt = S_START;
      S_START: w_state_nxt = S_RUN;
      S_RUN: begin
        if (eng_ack)       w_state_nxt = S_DONE;
        else if (w_wd_hit) w_state_nxt = S_ABORT;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ABORT: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_g     <= 1'b0;
      r_last  <= 1'b1;
      r_gnt   <= '0;
      r_fetch <= '0;
      r_emit  <= '0;
      r_fout  <= 1'b0;
      r_pe    <= 1'b0;
      r_ack2  <= 1'b0;
      r_ack3  <= 1'b0;
      r_eng_a <= '0;
      r_eng_b <= '0;
      r_out   <= '0;
      r_wd    <= '0;
    end else begin
      r_fetch <= '0;
      r_ack2  <= 1'b0;
      r_ack3  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_wd <= '0;
          if (|req) begin
            r_g     <= w_gi;
            r_gnt   <= w_gi ? 2'b10 : 2'b01;
            r_eng_a <= w_gi ? len1 : len0;
          end
        end
        S_RUN: begin
          r_wd <= w_act ? '0 : r_wd + WDW'(1);
          if (eng_start2) begin
            r_fetch <= w_onehot;
            r_fout  <= 1'b1;
          end else if (r_fout && w_fv) begin
            r_fout  <= 1'b0;
            r_eng_b <= r_g ? dat1 : dat0;
            r_ack2  <= 1'b1;
          end
          if (eng_start3) begin
            r_out <= eng_R;
            if (w_fbusy) r_pe   <= 1'b1;
            else         r_emit <= w_onehot;
          end else if (r_pe && !w_fbusy) begin
            r_pe   <= 1'b0;
            r_emit <= w_onehot;
          end else if ((|r_emit) && w_ea) begin
            r_emit <= '0;
            r_ack3 <= 1'b1;
          end
        end
        S_DONE, S_ABORT: begin
          r_gnt  <= '0;
          r_last <= r_g;
          r_emit <= '0;
          r_fout <= 1'b0;
          r_pe   <= 1'b0;
          r_wd   <= '0;
        end
        default: r_wd <= '0;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign fetch     = r_fetch;
  assign emit      = r_emit;
  assign out_dat   = r_out;
  assign eng_A     = r_eng_a;
  assign eng_B     = r_eng_b;
  assign eng_ack2  = r_ack2;
  assign eng_ack3  = r_ack3;
  assign eng_start = (r_state == S_START);
  assign done      = (r_state == S_DONE)  ? w_onehot : 2'b00;
  assign err       = (r_state == S_ABORT) ? w_onehot : 2'b00;

endmodule

// File: tb/tb_ord_arbiter.sv
// Bench for ord_arbiter: plays both requesters and the engine, keeps an expected-output model, compares every cycle.
module tb_ord_arbiter;
  localparam int W  = 8;
  localparam int WD = 24;

  logic         Clk;
  logic         Rst_n;
  logic [1:0]   req;
  logic [W-1:0] len0, len1, dat0, dat1;
  logic [1:0]   fvalid, fetch, emit, eack, gnt, done, err;
  logic [W-1:0] out_dat, eng_A, eng_B, eng_R;
  logic         eng_start, eng_ack, eng_start2, eng_ack2, eng_start3, eng_ack3;

  ord_arbiter #(.W(W), .WD_MAX(WD)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .req(req), .len0(len0), .len1(len1),
    .dat0(dat0), .dat1(dat1), .fvalid(fvalid), .fetch(fetch), .emit(emit),
    .eack(eack), .out_dat(out_dat), .gnt(gnt), .done(done), .err(err),
    .eng_start(eng_start), .eng_A(eng_A), .eng_B(eng_B), .eng_ack(eng_ack),
    .eng_start2(eng_start2), .eng_ack2(eng_ack2), .eng_start3(eng_start3),
    .eng_R(eng_R), .eng_ack3(eng_ack3)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Expected outputs for the current cycle; single-cycle pulses are cleared by tick().
  logic [1:0]   m_gnt, m_fetch, m_emit, m_done, m_err;
  logic         m_start, m_ack2, m_ack3;
  logic [W-1:0] m_a, m_b, m_out;
  bit           cmp_en;
  int           n_chk, n_pass, n_fail;
  int           n_done_seen, n_err_seen;
  logic [W-1:0] got[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh(input int g);
    return (g != 0) ? 2'b10 : 2'b01;
  endfunction

  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("gnt", 32'(gnt), 32'(m_gnt));
      chk("fetch", 32'(fetch), 32'(m_fetch));
      chk("emit", 32'(emit), 32'(m_emit));
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_err));
      chk("eng_start", 32'(eng_start), 32'(m_start));
      chk("eng_ack2", 32'(eng_ack2), 32'(m_ack2));
      chk("eng_ack3", 32'(eng_ack3), 32'(m_ack3));
      chk("eng_B", 32'(eng_B), 32'(m_b));
      if (m_start) chk("eng_A", 32'(eng_A), 32'(m_a));
      if (m_emit != 2'b00) chk("out_dat", 32'(out_dat), 32'(m_out));
      if (done != 2'b00) n_done_seen++;
      if (err != 2'b00) n_err_seen++;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
    m_fetch = 2'b00; m_ack2 = 1'b0; m_ack3 = 1'b0;
    m_done  = 2'b00; m_err  = 2'b00; m_start = 1'b0;
  endtask

  task automatic model_clear();
    m_gnt = 2'b00; m_fetch = 2'b00; m_emit = 2'b00; m_done = 2'b00; m_err = 2'b00;
    m_start = 1'b0; m_ack2 = 1'b0; m_ack3 = 1'b0; m_a = '0; m_b = '0; m_out = '0;
  endtask

  // Leaves the bench in the first RUN cycle.
  task automatic start_job(input logic [1:0] rq, input int g, input logic [W-1:0] ln);
    req = rq;
    tick();
    m_gnt = oh(g); m_start = 1'b1; m_a = ln;
    tick();
  endtask

  task automatic fetch_word(input int g, input logic [W-1:0] d);
    eng_start2 = 1'b1;
    tick();
    eng_start2 = 1'b0;
    m_fetch = oh(g);
    if (g != 0) dat1 = d; else dat0 = d;
    fvalid = oh(g);
    tick();
    fvalid = 2'b00;
    m_ack2 = 1'b1; m_b = d;
  endtask

  task automatic emit_word(input int g, input logic [W-1:0] r, input int hold);
    eng_start3 = 1'b1; eng_R = r;
    tick();
    eng_start3 = 1'b0;
    m_emit = oh(g); m_out = r;
    for (int i = 0; i < hold; i++) begin
      eack = (i == 5) ? oh(1 - g) : 2'b00;
      tick();
    end
    eack = 2'b00;
    got.push_back(out_dat);
    eack = oh(g);
    tick();
    eack = 2'b00;
    m_emit = 2'b00; m_ack3 = 1'b1;
  endtask

  // Fetch and emit requested together: the fetch must complete before emit rises.
  task automatic fetch_emit_same(input int g, input logic [W-1:0] d, input logic [W-1:0] r);
    eng_start2 = 1'b1; eng_start3 = 1'b1; eng_R = r;
    tick();
    eng_start2 = 1'b0; eng_start3 = 1'b0;
    m_fetch = oh(g);
    if (g != 0) dat1 = d; else dat0 = d;
    fvalid = oh(g);
    tick();
    fvalid = 2'b00;
    m_ack2 = 1'b1; m_b = d;
    tick();
    m_emit = oh(g); m_out = r;
    eack = oh(g);
    tick();
    eack = 2'b00;
    m_emit = 2'b00; m_ack3 = 1'b1;
  endtask

  // Leaves the bench in the IDLE cycle following the done pulse.
  task automatic finish_job(input int g);
    eng_ack = 1'b1;
    tick();
    eng_ack = 1'b0;
    m_done = oh(g);
    req[g] = 1'b0;
    tick();
    m_gnt = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0; n_done_seen = 0; n_err_seen = 0;
    cmp_en = 1'b0;
    Rst_n = 1'b1; req = 2'b00; len0 = '0; len1 = '0; dat0 = '0; dat1 = '0;
    fvalid = 2'b00; eack = 2'b00; eng_R = '0;
    eng_ack = 1'b0; eng_start2 = 1'b0; eng_start3 = 1'b0;
    model_clear();
    #2 Rst_n = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_eng_start", 32'(eng_start), 32'h0);
    chk("rst_eng_A", 32'(eng_A), 32'h0);
    chk("rst_out_dat", 32'(out_dat), 32'h0);
    chk("rst_done_err", 32'({done, err}), 32'h0);
    cmp_en = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;

    // Contention from reset: requester 0 first, stray fvalids ignored.
    len0 = 8'd1; len1 = 8'd2;
    start_job(2'b11, 0, 8'd1);
    dat1 = 8'hEE; fvalid = 2'b10;
    tick();
    dat0 = 8'hDD; fvalid = 2'b01;
    tick();
    fvalid = 2'b00;
    fetch_word(0, 8'h11);
    emit_word(0, 8'h11, 0);
    finish_job(0);

    // Requester 1 next, with 20 cycles of emit backpressure.
    start_job(2'b10, 1, 8'd2);
    fetch_word(1, 8'hA5);
    fetch_word(1, 8'h3C);
    emit_word(1, 8'h3C, 20);
    emit_word(1, 8'hA5, 0);
    finish_job(1);

    // Fresh tie after serving 1: requester 0 wins; zero-length job.
    len0 = 8'd0;
    start_job(2'b11, 0, 8'd0);
    finish_job(0);

    // Requester 1 still holding req; fetch and emit requested together.
    len1 = 8'd1;
    start_job(2'b10, 1, 8'd1);
    fetch_emit_same(1, 8'h66, 8'h66);
    finish_job(1);

    // Single job: 7,8,9 fetched, emitted reversed.
    len0 = 8'd3;
    got.delete();
    start_job(2'b01, 0, 8'd3);
    fetch_word(0, 8'd7);
    fetch_word(0, 8'd8);
    fetch_word(0, 8'd9);
    emit_word(0, 8'd9, 0);
    emit_word(0, 8'd8, 0);
    emit_word(0, 8'd7, 0);
    finish_job(0);
    chk("rev_count", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      chk("rev_0", 32'(got[0]), 32'd9);
      chk("rev_1", 32'(got[1]), 32'd8);
      chk("rev_2", 32'(got[2]), 32'd7);
    end

    // Watchdog: the fetched word never arrives.
    len0 = 8'd5;
    start_job(2'b01, 0, 8'd5);
    eng_start2 = 1'b1;
    tick();
    eng_start2 = 1'b0;
    m_fetch = oh(0);
    repeat (WD - 1) tick();
    tick();
    m_err = oh(0);
    req = 2'b00;
    tick();
    m_gnt = 2'b00;
    tick();

    // Reset in the middle of an emit: everything drops at once, no done/err.
    len0 = 8'd4;
    start_job(2'b01, 0, 8'd4);
    fetch_word(0, 8'h42);
    eng_start3 = 1'b1; eng_R = 8'h99;
    tick();
    eng_start3 = 1'b0;
    m_emit = oh(0); m_out = 8'h99;
    #2;
    model_clear();
    Rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 32'h0);
    chk("arst_emit", 32'(emit), 32'h0);
    chk("arst_out_dat", 32'(out_dat), 32'h0);
    chk("arst_eng_B", 32'(eng_B), 32'h0);
    chk("arst_eng_A", 32'(eng_A), 32'h0);
    req = 2'b00;
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;
    len1 = 8'd1;
    start_job(2'b10, 1, 8'd1);
    fetch_word(1, 8'h5A);
    emit_word(1, 8'h5A, 0);
    finish_job(1);
    tick();

    chk("done_pulses", 32'(n_done_seen), 32'd6);
    chk("err_pulses", 32'(n_err_seen), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
